// File: rtl/alu_pkg.sv
// Shared opcode encodings, instruction field positions and datapath sizing
// for the ALU issue stage.
package alu_pkg;

    localparam int XLEN  = 32;
    localparam int NREGS = 32;
    localparam int AW    = 5;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_NOT = 4'd2;
    localparam logic [3:0] OP_AND = 4'd3;
    localparam logic [3:0] OP_OR  = 4'd4;
    localparam logic [3:0] OP_XOR = 4'd5;
    localparam logic [3:0] OP_SLL = 4'd6;
    localparam logic [3:0] OP_SRL = 4'd7;
    localparam logic [3:0] OP_SRA = 4'd8;
    localparam logic [3:0] OP_MAX = 4'd8;

    localparam int OP_LSB = 28;
    localparam int RD_LSB = 23;
    localparam int RS_LSB = 18;
    localparam int RT_LSB = 13;

    function automatic logic op_legal(input logic [3:0] op);
        return op <= OP_MAX;
    endfunction

endpackage

// File: rtl/regfile_2r1w.sv
// Two asynchronous read ports, one synchronous write port; r0 reads zero
// and ignores writes.
module regfile_2r1w
    import alu_pkg::*;
#(
    parameter int          NREGS    = alu_pkg::NREGS,
    parameter int          XLEN     = alu_pkg::XLEN,
    parameter logic [31:0] RESET_R1 = 32'd0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [AW-1:0]   raddr_a_i,
    input  logic [AW-1:0]   raddr_b_i,
    output logic [XLEN-1:0] rdata_a_o,
    output logic [XLEN-1:0] rdata_b_o,
    input  logic            we_i,
    input  logic [AW-1:0]   waddr_i,
    input  logic [XLEN-1:0] wdata_i
);

    logic [XLEN-1:0] mem_q [NREGS];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < NREGS; i++) begin
                mem_q[i] <= XLEN'(RESET_R1);
            end
        end else if (we_i && waddr_i != '0) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    assign rdata_a_o = (raddr_a_i == '0) ? '0 : mem_q[raddr_a_i];
    assign rdata_b_o = (raddr_b_i == '0) ? '0 : mem_q[raddr_b_i];

endmodule

// File: rtl/alu_operand_fetch.sv
// ALU issue stage: decode, register read with writeback bypass, hazard
// scoreboard and a registered valid/ready operand slot.
module alu_operand_fetch
    import alu_pkg::*;
#(
    parameter int          NREGS    = alu_pkg::NREGS,
    parameter int          XLEN     = alu_pkg::XLEN,
    parameter logic [31:0] RESET_R1 = 32'd0
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [31:0]     instr,
    output logic            alu_valid,
    input  logic            alu_ready,
    output logic [XLEN-1:0] operandA,
    output logic [XLEN-1:0] operandB,
    output logic [3:0]      opCode,
    output logic [4:0]      alu_rd,
    input  logic            wb_en,
    input  logic [4:0]      wb_addr,
    input  logic [XLEN-1:0] wb_data,
    output logic            illegal_op
);

    logic [3:0]      op;
    logic [AW-1:0]   rd, rs, rt;
    logic [XLEN-1:0] rf_a, rf_b, byp_a, byp_b;
    logic [NREGS-1:0] pend_q, pend_d, pend_eff, wb_clr;
    logic            valid_q, valid_d;
    logic [XLEN-1:0] opa_q, opa_d, opb_q, opb_d;
    logic [3:0]      op_q, op_d;
    logic [4:0]      rd_q, rd_d;
    logic            ill_q, ill_d;
    logic            slot_free, hazard, accept, legal;
    logic            unused_bits;

    assign op = instr[OP_LSB +: 4];
    assign rd = instr[RD_LSB +: AW];
    assign rs = instr[RS_LSB +: AW];
    assign rt = instr[RT_LSB +: AW];
    assign unused_bits = ^instr[12:0];

    regfile_2r1w #(
        .NREGS    (NREGS),
        .XLEN     (XLEN),
        .RESET_R1 (RESET_R1)
    ) u_rf (
        .clk       (clk),
        .rst_n     (rst_n),
        .raddr_a_i (rs),
        .raddr_b_i (rt),
        .rdata_a_o (rf_a),
        .rdata_b_o (rf_b),
        .we_i      (wb_en),
        .waddr_i   (wb_addr),
        .wdata_i   (wb_data)
    );

    // A register written back this cycle is already resolved for issue.
    assign wb_clr   = wb_en ? ({{(NREGS-1){1'b0}}, 1'b1} << wb_addr) : '0;
    assign pend_eff = pend_q & ~wb_clr;

    assign byp_a = (wb_en && wb_addr == rs && rs != '0) ? wb_data : rf_a;
    assign byp_b = (wb_en && wb_addr == rt && rt != '0) ? wb_data : rf_b;

    assign slot_free = !valid_q || alu_ready;
    assign hazard    = pend_eff[rs] | pend_eff[rt] | pend_eff[rd];
    assign in_ready  = rst_n && slot_free && !hazard;
    assign accept    = in_valid && in_ready;
    assign legal     = op_legal(op);

    always_comb begin
        valid_d = valid_q;
        opa_d   = opa_q;
        opb_d   = opb_q;
        op_d    = op_q;
        rd_d    = rd_q;
        ill_d   = accept && !legal;
        pend_d  = pend_eff;
        if (accept && legal) begin
            valid_d = 1'b1;
            opa_d   = byp_a;
            opb_d   = byp_b;
            op_d    = op;
            rd_d    = rd;
            pend_d[rd] = 1'b1;
        end else if (slot_free) begin
            valid_d = 1'b0;
        end
        pend_d[0] = 1'b0;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q <= 1'b0;
            opa_q   <= '0;
            opb_q   <= '0;
            op_q    <= '0;
            rd_q    <= '0;
            ill_q   <= 1'b0;
            pend_q  <= '0;
        end else begin
            valid_q <= valid_d;
            opa_q   <= opa_d;
            opb_q   <= opb_d;
            op_q    <= op_d;
            rd_q    <= rd_d;
            ill_q   <= ill_d;
            pend_q  <= pend_d;
        end
    end

    assign alu_valid  = valid_q;
    assign operandA   = opa_q;
    assign operandB   = opb_q;
    assign opCode     = op_q;
    assign alu_rd     = rd_q;
    assign illegal_op = ill_q;

endmodule

// File: tb/tb_alu_operand_fetch.sv
// Scoreboard bench for alu_operand_fetch: expected slots queued at issue,
// compared when the ALU consumes them.
module tb_alu_operand_fetch;

    typedef struct {
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  op;
        logic [4:0]  rd;
    } exp_t;

    logic        clk = 0;
    logic        rst_n = 0;
    logic        in_valid = 0;
    logic        in_ready;
    logic [31:0] instr = '0;
    logic        alu_valid;
    logic        alu_ready = 1;
    logic [31:0] operandA, operandB;
    logic [3:0]  opCode;
    logic [4:0]  alu_rd;
    logic        wb_en = 0;
    logic [4:0]  wb_addr = '0;
    logic [31:0] wb_data = '0;
    logic        illegal_op;

    int n_checks = 0;
    int n_fail = 0;
    exp_t q[$];
    exp_t e;
    logic [31:0] regs_m [32];

    alu_operand_fetch dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .instr      (instr),
        .alu_valid  (alu_valid),
        .alu_ready  (alu_ready),
        .operandA   (operandA),
        .operandB   (operandB),
        .opCode     (opCode),
        .alu_rd     (alu_rd),
        .wb_en      (wb_en),
        .wb_addr    (wb_addr),
        .wb_data    (wb_data),
        .illegal_op (illegal_op)
    );

    always #5 clk = ~clk;

    function automatic logic [31:0] mk(input logic [3:0] op, input logic [4:0] rd,
                                       input logic [4:0] rs, input logic [4:0] rt);
        return {op, rd, rs, rt, 13'h0};
    endfunction

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic wb(input logic [4:0] a, input logic [31:0] d);
        wb_en = 1; wb_addr = a; wb_data = d;
        cyc();
        if (a != 0) regs_m[a] = d;
        wb_en = 0;
    endtask

    always @(negedge clk) begin
        if (rst_n && alu_valid && alu_ready) begin
            n_checks++;
            if (q.size() == 0) begin
                n_fail++;
                $display("FAIL slot_unexpected: got rd=%0d op=%0d, none expected", alu_rd, opCode);
            end else begin
                e = q.pop_front();
                if (operandA !== e.a || operandB !== e.b || opCode !== e.op || alu_rd !== e.rd) begin
                    n_fail++;
                    $display("FAIL slot_data: got A=%h B=%h op=%0d rd=%0d want A=%h B=%h op=%0d rd=%0d",
                             operandA, operandB, opCode, alu_rd, e.a, e.b, e.op, e.rd);
                end
            end
        end
    end

    task automatic test_reset();
        for (int i = 0; i < 32; i++) regs_m[i] = '0;
        rst_n = 0;
        #3;
        n_checks++;
        if (alu_valid !== 0 || in_ready !== 0 || operandA !== 0 || operandB !== 0 ||
            opCode !== 0 || alu_rd !== 0 || illegal_op !== 0) begin
            n_fail++;
            $display("FAIL reset_state: valid=%b rdy=%b A=%h B=%h op=%0d rd=%0d ill=%b want all 0",
                     alu_valid, in_ready, operandA, operandB, opCode, alu_rd, illegal_op);
        end
        cyc(); cyc();
        rst_n = 1;
        cyc();
    endtask

    task automatic test_issue_add();
        wb(5'd1, 32'hAABBCCDD);
        wb(5'd2, 32'hE1223341);
        in_valid = 1; instr = mk(4'd0, 5'd3, 5'd1, 5'd2);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1) begin
            n_fail++;
            $display("FAIL add_ready: got %b want 1", in_ready);
        end
        q.push_back('{32'hAABBCCDD, 32'hE1223341, 4'd0, 5'd3});
        cyc();
    endtask

    task automatic test_raw_stall();
        instr = mk(4'd1, 5'd4, 5'd3, 5'd1);
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 0) begin
                n_fail++;
                $display("FAIL raw_stall cycle %0d: in_ready=%b want 0", i, in_ready);
            end
            cyc();
        end
        wb_en = 1; wb_addr = 5'd3; wb_data = 32'h8BDE001E;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1) begin
            n_fail++;
            $display("FAIL raw_release: in_ready=%b want 1", in_ready);
        end
        q.push_back('{32'h8BDE001E, regs_m[1], 4'd1, 5'd4});
        cyc();
        regs_m[3] = 32'h8BDE001E;
        wb_en = 0; in_valid = 0;
        cyc();
    endtask

    task automatic test_backpressure();
        alu_ready = 0;
        in_valid = 1; instr = mk(4'd0, 5'd5, 5'd1, 5'd2);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1) begin
            n_fail++;
            $display("FAIL bp_first_ready: in_ready=%b want 1", in_ready);
        end
        q.push_back('{regs_m[1], regs_m[2], 4'd0, 5'd5});
        cyc();
        instr = mk(4'd0, 5'd6, 5'd1, 5'd2);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            n_checks++;
            if (in_ready !== 0 || alu_valid !== 1 || operandA !== 32'hAABBCCDD ||
                operandB !== 32'hE1223341 || opCode !== 4'd0 || alu_rd !== 5'd5) begin
                n_fail++;
                $display("FAIL bp_hold cycle %0d: rdy=%b v=%b A=%h B=%h op=%0d rd=%0d", i,
                         in_ready, alu_valid, operandA, operandB, opCode, alu_rd);
            end
            cyc();
        end
        in_valid = 0;
        alu_ready = 1;
        cyc();
        @(negedge clk);
        n_checks++;
        if (alu_valid !== 0) begin
            n_fail++;
            $display("FAIL bp_drain: alu_valid=%b want 0", alu_valid);
        end
        cyc();
    endtask

    task automatic test_illegal();
        in_valid = 1; instr = mk(4'b1011, 5'd7, 5'd1, 5'd2);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1) begin
            n_fail++;
            $display("FAIL ill_ready: in_ready=%b want 1", in_ready);
        end
        cyc();
        in_valid = 0;
        @(negedge clk);
        n_checks++;
        if (illegal_op !== 1 || alu_valid !== 0) begin
            n_fail++;
            $display("FAIL ill_pulse: illegal_op=%b alu_valid=%b want 1,0", illegal_op, alu_valid);
        end
        cyc();
        in_valid = 1; instr = mk(4'd0, 5'd8, 5'd7, 5'd0);
        @(negedge clk);
        n_checks++;
        if (illegal_op !== 0 || in_ready !== 1) begin
            n_fail++;
            $display("FAIL ill_after: illegal_op=%b in_ready=%b want 0,1", illegal_op, in_ready);
        end
        q.push_back('{regs_m[7], 32'h0, 4'd0, 5'd8});
        cyc();
        in_valid = 0;
        cyc();
    endtask

    task automatic test_r0();
        wb(5'd0, 32'hFFFFFFFF);
        in_valid = 1; instr = mk(4'd4, 5'd0, 5'd0, 5'd1);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1) begin
            n_fail++;
            $display("FAIL r0_first_ready: in_ready=%b want 1", in_ready);
        end
        q.push_back('{32'h0, regs_m[1], 4'd4, 5'd0});
        cyc();
        instr = mk(4'd0, 5'd9, 5'd0, 5'd0);
        wb_en = 1; wb_addr = 5'd0; wb_data = 32'hFFFFFFFF;
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1) begin
            n_fail++;
            $display("FAIL r0_no_stall: in_ready=%b want 1", in_ready);
        end
        q.push_back('{32'h0, 32'h0, 4'd0, 5'd9});
        cyc();
        wb_en = 0; in_valid = 0;
        cyc();
    endtask

    task automatic test_reset_mid();
        alu_ready = 0;
        in_valid = 1; instr = mk(4'd0, 5'd3, 5'd1, 5'd2);
        cyc();
        in_valid = 0;
        @(negedge clk);
        n_checks++;
        if (alu_valid !== 1) begin
            n_fail++;
            $display("FAIL rm_full: alu_valid=%b want 1", alu_valid);
        end
        #1;
        rst_n = 0;
        #1;
        n_checks++;
        if (alu_valid !== 0 || in_ready !== 0) begin
            n_fail++;
            $display("FAIL rm_async: alu_valid=%b in_ready=%b want 0,0", alu_valid, in_ready);
        end
        for (int i = 0; i < 32; i++) regs_m[i] = '0;
        cyc(); cyc();
        rst_n = 1;
        alu_ready = 1;
        cyc();
        in_valid = 1; instr = mk(4'd1, 5'd4, 5'd3, 5'd8);
        @(negedge clk);
        n_checks++;
        if (in_ready !== 1) begin
            n_fail++;
            $display("FAIL rm_sb_clear: in_ready=%b want 1", in_ready);
        end
        q.push_back('{regs_m[3], regs_m[8], 4'd1, 5'd4});
        cyc();
        in_valid = 0;
        repeat (3) cyc();
        n_checks++;
        if (q.size() !== 0) begin
            n_fail++;
            $display("FAIL sb_drain: %0d slots never produced, want 0", q.size());
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        test_reset();
        test_issue_add();
        test_raw_stall();
        test_backpressure();
        test_illegal();
        test_r0();
        test_reset_mid();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
